// File: rtl/fma_feeder.sv
// Operand feeder for the 3x3 FMA cluster. It holds matrices A and B and streams
// them into the cluster in three lockstep beats, then waits for the nine per-cell
// ready bits (or a timeout) and pulses done.

module fma_feeder_lane #(
  parameter int VEC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [VEC_W-1:0] beat_data,
  output logic             req,
  output logic [VEC_W-1:0] data
);
  // The data register only loads on issue, so it holds the last beat while req is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req  <= 1'b0;
      data <= '0;
    end else begin
      req <= issue;
      if (issue) data <= beat_data;
    end
  end
endmodule

module fma_feeder #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic [3:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        start,
  output logic [2:0]  float_0_req_out,
  output logic [31:0] float_0_data_0_out,
  output logic [31:0] float_0_data_1_out,
  output logic [31:0] float_0_data_2_out,
  input  logic [2:0]  float_0_busy_in,
  output logic [2:0]  float_1_req_out,
  output logic [31:0] float_1_data_0_out,
  output logic [31:0] float_1_data_1_out,
  output logic [31:0] float_1_data_2_out,
  input  logic [2:0]  float_1_busy_in,
  input  logic [8:0]  ready_in,
  input  logic        error_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 32;
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;

  state_t     state, state_nx;
  logic [1:0] k, k_nx;
  logic [8:0] mask, mask_nx, mask_or;
  logic [7:0] tcnt, tcnt_nx;
  logic       err_nx;
  logic       issue;
  logic [3:0] k3;

  logic [8:0][VEC_W-1:0]           a_mem, b_mem;
  logic [NUM_LANES-1:0][VEC_W-1:0] a_beat, b_beat, a_q, b_q;
  logic [NUM_LANES-1:0]            a_req, b_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_mem <= '0;
      b_mem <= '0;
    end else if (state == IDLE && load_en && load_addr < 4'd9) begin
      if (load_sel) b_mem[load_addr] <= load_data;
      else          a_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      mask      <= '0;
      tcnt      <= '0;
      error_out <= 1'b0;
    end else begin
      state     <= state_nx;
      k         <= k_nx;
      mask      <= mask_nx;
      tcnt      <= tcnt_nx;
      error_out <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    k_nx     = k;
    mask_nx  = mask;
    tcnt_nx  = tcnt;
    err_nx   = error_out;
    issue    = 1'b0;
    mask_or  = mask | ready_in;
    case (state)
      IDLE: if (start) begin
        k_nx     = '0;
        mask_nx  = '0;
        tcnt_nx  = '0;
        err_nx   = 1'b0;
        state_nx = ISSUE;
      end
      ISSUE: begin
        mask_nx = mask_or;
        if (~|{float_0_busy_in, float_1_busy_in}) begin
          issue    = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        mask_nx = mask_or;
        if (k == 2'd2) state_nx = DRAIN;
        else begin
          k_nx     = k + 2'd1;
          state_nx = ISSUE;
        end
      end
      DRAIN: begin
        mask_nx = mask_or;
        // A completing mask beats the timeout when both land in the same cycle.
        if (mask_or == 9'h1FF) state_nx = DONE;
        else if (tcnt == TMO) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else tcnt_nx = tcnt + 8'd1;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && error_in) err_nx = 1'b1;
  end

  // A row i reads A[i*3+k]; B column j reads B[k*3+j].
  assign k3 = {2'b00, k} + {1'b0, k, 1'b0};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [3:0] a_idx, b_idx;
      assign a_idx     = 4'(g * 3) + {2'b00, k};
      assign b_idx     = k3 + 4'(g);
      assign a_beat[g] = a_mem[a_idx];
      assign b_beat[g] = b_mem[b_idx];

      fma_feeder_lane #(.VEC_W(VEC_W)) u_a (
        .clk(clk), .rst(rst), .issue(issue), .beat_data(a_beat[g]),
        .req(a_req[g]), .data(a_q[g])
      );
      fma_feeder_lane #(.VEC_W(VEC_W)) u_b (
        .clk(clk), .rst(rst), .issue(issue), .beat_data(b_beat[g]),
        .req(b_req[g]), .data(b_q[g])
      );
    end
  endgenerate

  assign float_0_req_out    = a_req;
  assign float_0_data_0_out = a_q[0];
  assign float_0_data_1_out = a_q[1];
  assign float_0_data_2_out = a_q[2];
  assign float_1_req_out    = b_req;
  assign float_1_data_0_out = b_q[0];
  assign float_1_data_1_out = b_q[1];
  assign float_1_data_2_out = b_q[2];
  assign busy_out           = (state != IDLE);
  assign done_out           = (state == DONE);
endmodule

// File: tb/tb_fma_feeder.sv
// Directed bench for fma_feeder: a per-cycle vector table for the basic run plus
// hand sequences for backpressure, timeout, repeat ready, busy writes and reset.

module tb_fma_feeder;
  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000,
                          F4 = 32'h40800000, F5 = 32'h40A00000, F6 = 32'h40C00000,
                          F7 = 32'h40E00000, F8 = 32'h41000000, F9 = 32'h41100000;

  logic        clk = 1'b0, rst = 1'b0;
  logic        load_en = 0, load_sel = 0, start = 0, error_in = 0;
  logic [3:0]  load_addr = 0;
  logic [31:0] load_data = 0;
  logic [2:0]  f0_busy = 0, f1_busy = 0, f0_req, f1_req;
  logic [31:0] a0, a1, a2, b0, b1, b2;
  logic [8:0]  ready = 0;
  logic        busy_o, done_o, err_o;

  int total = 0, bad = 0;
  logic [31:0] aval [9];

  fma_feeder #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .start(start),
    .float_0_req_out(f0_req), .float_0_data_0_out(a0), .float_0_data_1_out(a1),
    .float_0_data_2_out(a2), .float_0_busy_in(f0_busy),
    .float_1_req_out(f1_req), .float_1_data_0_out(b0), .float_1_data_1_out(b1),
    .float_1_data_2_out(b2), .float_1_busy_in(f1_busy),
    .ready_in(ready), .error_in(error_in),
    .busy_out(busy_o), .done_out(done_o), .error_out(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [2:0]  bz0, bz1;
    logic [8:0]  rdy;
    logic [2:0]  req0, req1;
    logic        bsy, dn, er;
    logic [31:0] da0, da2, db1;
  } vec_t;
  vec_t vecs [11];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [3:0] addr, input logic [31:0] d);
    load_en = 1; load_sel = sel; load_addr = addr; load_data = d;
    tick();
    load_en = 0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 9; i++) load(1'b0, 4'(i), aval[i]);
    for (int i = 0; i < 9; i++) load(1'b1, 4'(i), (i % 4 == 0) ? F1 : 32'h0);
  endtask

  // Leaves the bench in cycle 1 (first ISSUE cycle).
  task automatic start_run();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    aval = '{F1, F2, F3, F4, F5, F6, F7, F8, F9};
    //          start bz0 bz1 rdy     req0 req1 bsy dn er  da0 da2 db1
    vecs[0]  = '{1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0,  0,  0};
    vecs[1]  = '{0, 0, 0, 9'h000, 0, 0, 1, 0, 0, 0,  0,  0};
    vecs[2]  = '{0, 0, 0, 9'h000, 7, 7, 1, 0, 0, F1, F7, 0};
    vecs[3]  = '{0, 0, 0, 9'h000, 0, 0, 1, 0, 0, F1, F7, 0};
    vecs[4]  = '{0, 0, 0, 9'h000, 7, 7, 1, 0, 0, F2, F8, F1};
    vecs[5]  = '{0, 0, 0, 9'h000, 0, 0, 1, 0, 0, F2, F8, F1};
    vecs[6]  = '{0, 0, 0, 9'h000, 7, 7, 1, 0, 0, F3, F9, 0};
    vecs[7]  = '{0, 0, 0, 9'h00F, 0, 0, 1, 0, 0, F3, F9, 0};
    vecs[8]  = '{0, 0, 0, 9'h1F0, 0, 0, 1, 0, 0, F3, F9, 0};
    vecs[9]  = '{0, 0, 0, 9'h000, 0, 0, 1, 1, 0, F3, F9, 0};
    vecs[10] = '{0, 0, 0, 9'h000, 0, 0, 0, 0, 0, F3, F9, 0};

    // Reset state, before any clock edge
    #2;
    chk("rst_req0", 32'(f0_req), 0); chk("rst_req1", 32'(f1_req), 0);
    chk("rst_data", a0 | a1 | a2 | b0 | b1 | b2, 0);
    chk("rst_busy", 32'(busy_o), 0); chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    #10 rst = 1;
    tick();
    load_all();

    // Basic run from the table
    for (int c = 0; c < 11; c++) begin
      start = vecs[c].start; f0_busy = vecs[c].bz0; f1_busy = vecs[c].bz1; ready = vecs[c].rdy;
      chk($sformatf("tbl c%0d req0", c), 32'(f0_req), 32'(vecs[c].req0));
      chk($sformatf("tbl c%0d req1", c), 32'(f1_req), 32'(vecs[c].req1));
      chk($sformatf("tbl c%0d busy", c), 32'(busy_o), 32'(vecs[c].bsy));
      chk($sformatf("tbl c%0d done", c), 32'(done_o), 32'(vecs[c].dn));
      chk($sformatf("tbl c%0d err", c),  32'(err_o),  32'(vecs[c].er));
      chk($sformatf("tbl c%0d a0", c), a0, vecs[c].da0);
      chk($sformatf("tbl c%0d a2", c), a2, vecs[c].da2);
      chk($sformatf("tbl c%0d b1", c), b1, vecs[c].db1);
      tick();
    end
    start = 0; ready = 0;

    // Backpressure on B lane 2 for 5 cycles during beat 1
    start_run();
    tick();
    chk("bp beat0 req", 32'(f0_req), 7);
    tick();
    for (int i = 0; i < 5; i++) begin
      f1_busy = 3'b100;
      chk($sformatf("bp hold%0d req0", i), 32'(f0_req), 0);
      chk($sformatf("bp hold%0d req1", i), 32'(f1_req), 0);
      tick();
    end
    f1_busy = 0;
    chk("bp drop req0", 32'(f0_req), 0);
    tick();
    chk("bp beat1 req0", 32'(f0_req), 7); chk("bp beat1 req1", 32'(f1_req), 7);
    chk("bp beat1 a0", a0, F2); chk("bp beat1 b1", b1, F1);
    tick();
    chk("bp gap2 req0", 32'(f0_req), 0);
    tick();
    chk("bp beat2 req0", 32'(f0_req), 7); chk("bp beat2 a0", a0, F3);
    tick();
    ready = 9'h1FF;
    tick();
    ready = 0;
    chk("bp done", 32'(done_o), 1); chk("bp err", 32'(err_o), 0);
    tick();

    // Timeout: bit 4 never arrives, TIMEOUT_CYCLES = 4, drain entry at cycle 7
    start_run();
    tick(6);
    ready = 9'h1EF;
    chk("to c7 done", 32'(done_o), 0);
    tick();
    ready = 0;
    for (int c = 8; c < 12; c++) begin
      chk($sformatf("to c%0d done", c), 32'(done_o), 0);
      tick();
    end
    chk("to c12 done", 32'(done_o), 1); chk("to c12 err", 32'(err_o), 1);
    tick();
    chk("to c13 done", 32'(done_o), 0); chk("to c13 err", 32'(err_o), 1);
    chk("to c13 busy", 32'(busy_o), 0);

    // Repeat pulse on ready bit 4 must not complete the mask early
    start_run();
    tick(2);
    ready = 9'h010;
    tick();
    ready = 0;
    tick(3);
    ready = 9'h0EF;
    chk("rep c7 done", 32'(done_o), 0);
    tick();
    ready = 9'h100;
    chk("rep c8 done", 32'(done_o), 0);
    tick();
    ready = 0;
    chk("rep c9 done", 32'(done_o), 1); chk("rep c9 err", 32'(err_o), 0);
    tick();
    chk("rep c10 done", 32'(done_o), 0);

    // Writes while busy and to addr 12 are dropped
    start_run();
    load_en = 1; load_sel = 0; load_addr = 0; load_data = F4;
    tick();
    load_en = 0;
    tick(5);
    ready = 9'h1FF;
    tick();
    ready = 0;
    tick(2);
    load(1'b0, 4'd12, 32'hDEADBEEF);
    start_run();
    tick();
    chk("ld beat0 a0", a0, F1); chk("ld beat0 a1", a1, F4);
    tick(2);
    chk("ld beat1 a0", a0, F2); chk("ld beat1 a1", a1, F5);
    tick(3);
    ready = 9'h1FF;
    tick();
    ready = 0;
    tick(2);

    // Async reset in the GAP of beat 1, with error_out already set
    start_run();
    tick(2);
    error_in = 1;
    tick();
    error_in = 0;
    chk("ar pre req0", 32'(f0_req), 7); chk("ar pre err", 32'(err_o), 1);
    #2 rst = 0;
    #1;
    chk("ar req0", 32'(f0_req), 0); chk("ar req1", 32'(f1_req), 0);
    chk("ar data", a0 | a1 | a2 | b0 | b1 | b2, 0);
    chk("ar busy", 32'(busy_o), 0); chk("ar done", 32'(done_o), 0);
    chk("ar err", 32'(err_o), 0);
    @(negedge clk) rst = 1;
    tick();
    chk("ar idle busy", 32'(busy_o), 0); chk("ar idle done", 32'(done_o), 0);
    load_all();
    start_run();
    chk("ar2 c1 req0", 32'(f0_req), 0);
    for (int b = 0; b < 3; b++) begin
      tick();
      chk($sformatf("ar2 beat%0d req0", b), 32'(f0_req), 7);
      chk($sformatf("ar2 beat%0d req1", b), 32'(f1_req), 7);
      chk($sformatf("ar2 beat%0d a0", b), a0, aval[b]);
      tick();
      chk($sformatf("ar2 after%0d req0", b), 32'(f0_req), 0);
    end
    ready = 9'h1FF;
    tick();
    ready = 0;
    chk("ar2 done", 32'(done_o), 1); chk("ar2 err", 32'(err_o), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
